// File: rtl/regfile_scoreboard_pkg.sv
// Shared types and defaults for the register file / scoreboard slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package regfile_scoreboard_pkg;

    // Default datapath widths, also used by the ALU and control blocks.
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;

    // Architectural index of the hardwired zero register.
    localparam int REG_ZERO = 0;

    // ST_INIT walks the array writing zeros; ST_RUN accepts operations.
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_scoreboard_bits.sv
// Per-register busy vector: issue sets a bit, writeback clears it.
// Latency: updates on the clock edge; the vector is read combinationally.
// Backpressure: none; callers gate setEn/clrEn themselves.
//
// Ports: clk/rst (sync, active-high flush), setEn/setReg (issue),
//        clrEn/clrReg (writeback), busy (DEPTH-bit vector).
module regfile_scoreboard_bits #(
    parameter int ADDR_W = regfile_scoreboard_pkg::ADDR_W,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              setEn,
    input  logic [ADDR_W-1:0] setReg,
    input  logic              clrEn,
    input  logic [ADDR_W-1:0] clrReg,
    output logic [DEPTH-1:0]  busy
);

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            if (clrEn) begin
                busy[clrReg] <= 1'b0;
            end
            // Set comes last so an issue and a writeback to the same register
            // on one edge leave it busy: the newly issued producer still owes a write.
            if (setEn) begin
                busy[setReg] <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with NUM_RD read ports, one write port, bypass, zero register and RAW scoreboard.
// Latency: reads are combinational; writes/issues take effect on the next edge.
// Backpressure: none; ready stays low for DEPTH cycles after reset while the array is cleared.
//
// Ports: clk, rst (sync active-high), ready, reg_write/write_reg/write_data (write port),
//        issue_valid/issue_reg (mark destination busy), read_reg (packed addresses),
//        read_data (packed data), read_busy (per-port hazard flag).
module regfile_scoreboard #(
    parameter int DATA_W   = regfile_scoreboard_pkg::DATA_W,
    parameter int ADDR_W   = regfile_scoreboard_pkg::ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     ready,
    input  logic                     reg_write,
    input  logic [ADDR_W-1:0]        write_reg,
    input  logic [DATA_W-1:0]        write_data,
    input  logic                     issue_valid,
    input  logic [ADDR_W-1:0]        issue_reg,
    input  logic [NUM_RD*ADDR_W-1:0] read_reg,
    output logic [NUM_RD*DATA_W-1:0] read_data,
    output logic [NUM_RD-1:0]        read_busy
);

    import regfile_scoreboard_pkg::*;

    localparam int                DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state;
    state_t            stateNext;
    logic [ADDR_W-1:0] clrIdx;
    logic              running;
    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busyVec;
    logic              wrEn;
    logic              setEn;
    logic              clrEn;

    function automatic logic isZero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == ZERO_ADDR);
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_INIT;
        end else begin
            state <= stateNext;
        end
    end

    // Next state: leave INIT on the edge that clears the last register.
    always_comb begin
        stateNext = state;
        case (state)
            ST_INIT: if (clrIdx == LAST_ADDR) stateNext = ST_RUN;
            ST_RUN:  stateNext = ST_RUN;
            default: stateNext = ST_INIT;
        endcase
    end

    // Outputs of the FSM.
    always_comb begin
        running = (state == ST_RUN);
        ready   = running;
    end

    // Clear index advances only in INIT; it wraps back to 0 as INIT ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            clrIdx <= '0;
        end else if (state == ST_INIT) begin
            clrIdx <= clrIdx + ADDR_W'(1);
        end
    end

    assign wrEn  = running && reg_write && !isZero(write_reg);
    assign setEn = running && issue_valid && !isZero(issue_reg);
    assign clrEn = running && reg_write;

    // Storage has no reset of its own; INIT sweeps it to zero instead.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == ST_INIT) begin
                regs[clrIdx] <= '0;
            end else if (wrEn) begin
                regs[write_reg] <= write_data;
            end
        end
    end

    regfile_scoreboard_bits #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_bits (
        .clk    (clk),
        .rst    (rst),
        .setEn  (setEn),
        .setReg (issue_reg),
        .clrEn  (clrEn),
        .clrReg (write_reg),
        .busy   (busyVec)
    );

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              fwd;
        logic              quiet;

        assign addr  = read_reg[i*ADDR_W +: ADDR_W];
        // A write in flight to this address supplies the data and resolves the hazard now.
        assign fwd   = (BYPASS != 0) && reg_write && (write_reg == addr);
        assign quiet = !running || isZero(addr);

        assign read_data[i*DATA_W +: DATA_W] = quiet ? '0
                                             : (fwd ? write_data : regs[addr]);
        assign read_busy[i] = !quiet && !fwd && busyVec[addr];
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        regWrite = 1'b0;
    logic [4:0]  writeReg = '0;
    logic [31:0] writeData = '0;
    logic        issueValid = 1'b0;
    logic [4:0]  issueReg = '0;
    logic [9:0]  readReg = '0;

    logic        readyA, readyB;
    logic [63:0] rdA, rdB;
    logic [1:0]  rbA, rbB;

    logic        cWrite = 1'b0;
    logic [2:0]  cWreg = '0;
    logic [15:0] cWdata = '0;
    logic        cIssue = 1'b0;
    logic [2:0]  cIreg = '0;
    logic [11:0] cRreg = '0;
    logic        readyC;
    logic [63:0] rdC;
    logic [3:0]  rbC;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_scoreboard dutA (
        .clk(clk), .rst(rst), .ready(readyA),
        .reg_write(regWrite), .write_reg(writeReg), .write_data(writeData),
        .issue_valid(issueValid), .issue_reg(issueReg),
        .read_reg(readReg), .read_data(rdA), .read_busy(rbA)
    );

    regfile_scoreboard #(.BYPASS(0)) dutB (
        .clk(clk), .rst(rst), .ready(readyB),
        .reg_write(regWrite), .write_reg(writeReg), .write_data(writeData),
        .issue_valid(issueValid), .issue_reg(issueReg),
        .read_reg(readReg), .read_data(rdB), .read_busy(rbB)
    );

    regfile_scoreboard #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4)) dutC (
        .clk(clk), .rst(rst), .ready(readyC),
        .reg_write(cWrite), .write_reg(cWreg), .write_data(cWdata),
        .issue_valid(cIssue), .issue_reg(cIreg),
        .read_reg(cRreg), .read_data(rdC), .read_busy(rbC)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (32x32, shared stimulus for A and B) ----------------
    logic [31:0] mRegs [32];
    bit          mBusy [32];
    int          initLeft = 0;
    bit          mValid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            mValid   = 1'b1;
            initLeft = 32;
            foreach (mBusy[k]) mBusy[k] = 1'b0;
        end else if (mValid) begin
            if (initLeft > 0) begin
                // Whole array reads as zero once the clear sweep is over.
                initLeft--;
                if (initLeft == 0) foreach (mRegs[k]) mRegs[k] = '0;
            end else begin
                if (regWrite && writeReg != 0) mRegs[writeReg] = writeData;
                if (regWrite) mBusy[writeReg] = 1'b0;
                if (issueValid && issueReg != 0) mBusy[issueReg] = 1'b1;
            end
        end
    end

    function automatic logic [31:0] expData(input logic [4:0] a, input bit byp);
        if (initLeft != 0 || a == 0) return '0;
        if (byp && regWrite && writeReg == a) return writeData;
        return mRegs[a];
    endfunction

    function automatic logic expBusy(input logic [4:0] a, input bit byp);
        if (initLeft != 0 || a == 0) return 1'b0;
        if (byp && regWrite && writeReg == a) return 1'b0;
        return mBusy[a];
    endfunction

    always @(negedge clk) begin
        if (mValid) begin
            chk("ready_a", {63'd0, readyA}, {63'd0, initLeft == 0});
            chk("ready_b", {63'd0, readyB}, {63'd0, initLeft == 0});
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("data_a%0d", p), {32'd0, rdA[p*32 +: 32]}, {32'd0, expData(readReg[p*5 +: 5], 1'b1)});
                chk($sformatf("busy_a%0d", p), {63'd0, rbA[p]}, {63'd0, expBusy(readReg[p*5 +: 5], 1'b1)});
                chk($sformatf("data_b%0d", p), {32'd0, rdB[p*32 +: 32]}, {32'd0, expData(readReg[p*5 +: 5], 1'b0)});
                chk($sformatf("busy_b%0d", p), {63'd0, rbB[p]}, {63'd0, expBusy(readReg[p*5 +: 5], 1'b0)});
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic rw, input logic [4:0] wr, input logic [31:0] wd,
                         input logic iv, input logic [4:0] ir,
                         input logic [4:0] r0, input logic [4:0] r1);
        @(posedge clk);
        #2;
        regWrite = rw; writeReg = wr; writeData = wd;
        issueValid = iv; issueReg = ir;
        readReg = {r1, r0};
    endtask

    task automatic pulse_rst();
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1 chk("ready_in_rst", {63'd0, readyA}, 64'd0);
        #1 rst = 1'b0;
    endtask

    // Counts edges after rst falls until ready rises, for the 32- and 8-deep instances.
    task automatic wait_ready();
        int n  = 0;
        int nC = 0;
        while (!readyA && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (readyC && nC == 0) nC = n;
        end
        chk("init_len_a", 64'(n), 64'd32);
        chk("init_len_c", 64'(nC), 64'd8);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected end well before %0t", $time);
        $fatal(1);
    end

    initial begin
        readReg = {5'd31, 5'd8};
        pulse_rst();
        #1;
        chk("rst_ready", {63'd0, readyA}, 64'd0);
        chk("rst_data", rdA, 64'd0);
        chk("rst_busy", {62'd0, rbA}, 64'd0);

        // Reset again part-way through the clear sweep.
        repeat (9) @(posedge clk);
        pulse_rst();
        wait_ready();

        drive(1, 5'd8, 32'd10, 0, 5'd0, 5'd0, 5'd0);
        drive(1, 5'd9, 32'd20, 0, 5'd0, 5'd8, 5'd9);
        #2;
        chk("rd8_a", {32'd0, rdA[31:0]}, 64'd10);
        chk("byp9_a", {32'd0, rdA[63:32]}, 64'd20);
        chk("nobyp9_b", {32'd0, rdB[63:32]}, 64'd0);
        drive(0, 5'd0, 32'd0, 0, 5'd0, 5'd8, 5'd9);
        #2;
        chk("late9_b", {32'd0, rdB[63:32]}, 64'd20);

        drive(1, 5'd0, 32'hDEADBEEF, 1, 5'd0, 5'd0, 5'd0);
        #2;
        chk("zero_wr_a", {32'd0, rdA[31:0]}, 64'd0);
        chk("zero_wr_b", {32'd0, rdB[31:0]}, 64'd0);
        drive(0, 5'd0, 32'd0, 0, 5'd0, 5'd0, 5'd0);
        #2;
        chk("zero_rd", {32'd0, rdA[31:0]}, 64'd0);
        chk("zero_busy", {62'd0, rbA}, 64'd0);

        drive(0, 5'd0, 32'd0, 1, 5'd11, 5'd11, 5'd11);
        #2;
        chk("issue_pre", {62'd0, rbA}, 64'd0);
        drive(1, 5'd11, 32'd40, 0, 5'd0, 5'd11, 5'd11);
        #2;
        chk("wb_busy_a", {62'd0, rbA}, 64'd0);
        chk("wb_data_a", {32'd0, rdA[31:0]}, 64'd40);
        chk("wb_busy_b", {63'd0, rbB[0]}, 64'd1);
        chk("wb_data_b", {32'd0, rdB[31:0]}, 64'd0);
        drive(1, 5'd11, 32'd50, 1, 5'd11, 5'd11, 5'd11);
        #2;
        chk("same_edge_byp", {62'd0, rbA}, 64'd0);
        drive(0, 5'd0, 32'd0, 0, 5'd0, 5'd11, 5'd11);
        #2;
        chk("same_edge_busy", {62'd0, rbA}, 64'd3);
        chk("same_edge_data", rdA, {32'd50, 32'd50});

        // Reset in RUN with busy bits set; ops presented during INIT must be ignored.
        drive(0, 5'd0, 32'd0, 1, 5'd12, 5'd0, 5'd0);
        drive(1, 5'd5, 32'h55, 1, 5'd6, 5'd5, 5'd6);
        pulse_rst();
        wait_ready();
        drive(0, 5'd0, 32'd0, 0, 5'd0, 5'd8, 5'd11);
        #2;
        chk("post_rst_data", rdA, 64'd0);
        chk("post_rst_busy", {62'd0, rbA}, 64'd0);
        drive(0, 5'd0, 32'd0, 0, 5'd0, 5'd12, 5'd0);
        #2;
        chk("post_rst_busy12", {62'd0, rbA}, 64'd0);

        // Narrow four-port instance.
        @(posedge clk);
        #2 cWrite = 1'b1; cWreg = 3'd1; cWdata = 16'h1234;
        @(posedge clk);
        #2 cWreg = 3'd7; cWdata = 16'hFFFF;
        @(posedge clk);
        #2 cWreg = 3'd0; cWdata = 16'hBEEF;
        cRreg = {3'd0, 3'd7, 3'd1, 3'd1};
        #2;
        chk("c_ready", {63'd0, readyC}, 64'd1);
        chk("c_ports", rdC, {16'h0000, 16'hFFFF, 16'h1234, 16'h1234});
        chk("c_busy", {60'd0, rbC}, 64'd0);
        @(posedge clk);
        #2 cWrite = 1'b0;

        @(posedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
